// File: rtl/satd_pkg.sv
// Shared types and constants for the SATD control block: FSM state
// enumeration and the set of supported block dimensions.
package satd_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_VERT = 3'd2,
    S_ACC  = 3'd3,
    S_DONE = 3'd4
  } satd_state_e;

  localparam int BLK_LEGAL_N = 3;
  localparam int BLK_LEGAL [BLK_LEGAL_N] = '{4, 8, 16};

  function automatic logic blk_legal(input int b);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < BLK_LEGAL_N; i++) begin
      if (BLK_LEGAL[i] == b) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/satd_row_counter.sv
// Row counter that wraps to zero after reaching a programmable limit.
// last flags the final row so the FSM can leave a phase on that cycle.
module satd_row_counter #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count,
  output logic          last
);

  assign last = (count == limit);

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/satd_control_p.sv
// Control FSM for a SATD engine: sequences row load, vertical transform
// and accumulation phases over an L-row block (L = BLK or BLK/2).
module satd_control_p
  import satd_pkg::*;
#(
  parameter int BLK = 8,
  parameter int CW  = $clog2(BLK)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          half,
  input  logic          in_valid,
  output logic          ready,
  output logic          diff_en,
  output logic          hor_en,
  output logic          ver_en,
  output logic          acc_en,
  output logic          acc_clr,
  output logic [CW-1:0] row_idx,
  output logic          done,
  output logic [2:0]    dbg_state
);

  // Handshake: start is taken on a rising edge where ready=1 (IDLE or DONE);
  // in LOAD a row is consumed on each rising edge where in_valid=1.

  satd_state_e   state_q, state_d;
  logic [CW-1:0] lim_q;
  logic [CW-1:0] cnt;
  logic          cnt_last;
  logic          cnt_clear;
  logic          cnt_inc;
  logic          accept;

  assign accept = reset && start && (state_q == S_IDLE || state_q == S_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      lim_q   <= CW'(BLK - 1);
    end else begin
      state_q <= state_d;
      if (accept) lim_q <= half ? CW'(BLK / 2 - 1) : CW'(BLK - 1);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          cnt_clear = 1'b1;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          cnt_inc = 1'b1;
          if (cnt_last) state_d = S_VERT;
        end
      end
      S_VERT: begin
        cnt_inc = 1'b1;
        if (cnt_last) state_d = S_ACC;
      end
      S_ACC: begin
        cnt_inc = 1'b1;
        if (cnt_last) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_d   = S_LOAD;
          cnt_clear = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  satd_row_counter #(.CW(CW)) u_row_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear),
    .inc   (cnt_inc),
    .limit (lim_q),
    .count (cnt),
    .last  (cnt_last)
  );

  // Outputs decode registered state; reset gating keeps them quiet while held.
  assign ready     = reset && (state_q == S_IDLE || state_q == S_DONE);
  assign diff_en   = reset && (state_q == S_LOAD) && in_valid;
  assign hor_en    = reset && (state_q == S_LOAD) && in_valid;
  assign ver_en    = reset && (state_q == S_VERT);
  assign acc_en    = reset && (state_q == S_ACC);
  assign acc_clr   = reset && (state_q == S_ACC) && (cnt == '0);
  assign done      = reset && (state_q == S_DONE);
  assign row_idx   = cnt;
  assign dbg_state = state_q;

endmodule

// File: doc/satd_control_p.md
SATD_CONTROL_P -- requirements
Module: satd_control_p

Interface
REQ-001 The block SHALL have parameter BLK, default 8, meaning the maximum block dimension in rows; legal values are 4, 8 and 16.
REQ-002 The block SHALL have parameter CW, default $clog2(BLK), meaning the width of the row counter and of row_idx.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all logic is on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the reset: synchronous and active-low (0 = reset).
REQ-005 Port start, input, 1 bit, SHALL request one SATD block computation.
REQ-006 Port half, input, 1 bit, SHALL select the block size: 0 = BLK rows, 1 = BLK/2 rows; it is sampled together with start.
REQ-007 Port in_valid, input, 1 bit, SHALL indicate that a difference row is available for the current load cycle.
REQ-008 Port ready, output, 1 bit, SHALL indicate that start will be accepted this cycle.
REQ-009 Ports diff_en, hor_en, ver_en, acc_en, output, 1 bit each, SHALL be the datapath stage enables.
REQ-010 Port acc_clr, output, 1 bit, SHALL tell the accumulator to load the incoming value instead of adding it.
REQ-011 Port row_idx, output, CW bits, SHALL give the row currently being processed.
REQ-012 Port done, output, 1 bit, SHALL pulse for one cycle when the SATD result is valid.

Function
REQ-013 The FSM SHALL have five states: IDLE, LOAD, VERT, ACC, DONE.
REQ-014 The active row count L SHALL be latched when start is accepted: BLK if half=0, BLK/2 if half=1.
REQ-015 ready SHALL be 1 in IDLE and DONE, and 0 in all other states.
REQ-016 start SHALL be accepted only when ready=1; the next state is then LOAD with row_idx=0. In DONE this gives back-to-back blocks with no IDLE cycle.
REQ-017 When start arrives while ready=0, the block SHALL ignore it, with no queuing.
REQ-018 In LOAD, diff_en and hor_en SHALL equal in_valid; row_idx SHALL advance only on cycles where in_valid=1; in_valid=0 stalls the block with all enables low.
REQ-019 LOAD SHALL exit to VERT, with row_idx reset to 0, on the accepted cycle where row_idx=L-1.
REQ-020 VERT SHALL hold ver_en=1 for exactly L cycles, ignore in_valid, and then go to ACC with row_idx=0.
REQ-021 ACC SHALL hold acc_en=1 for exactly L cycles; acc_clr SHALL be 1 only on its first cycle (row_idx=0).
REQ-022 After ACC the FSM SHALL enter DONE for one cycle with done=1, then go to IDLE unless start is accepted.
REQ-023 With in_valid held at 1, done SHALL rise exactly 3*L+1 cycles after the cycle in which start is accepted.
REQ-024 row_idx SHALL never exceed L-1; in the half case the counter wraps at L-1, not at BLK-1.
REQ-025 Every output SHALL be a registered decode of state and counter, with no combinational path from start or in_valid, except diff_en and hor_en, which are gated by in_valid.

Reset
REQ-026 While reset=0 at a clock edge, the block SHALL force state IDLE, row_idx 0 and latched L = BLK.
REQ-027 During reset, all enables, acc_clr and done SHALL be 0, and ready SHALL be 1 from the first cycle after release.
REQ-028 A reset in the middle of an operation SHALL abandon the block immediately, with no done pulse.

Structure
REQ-029 Package satd_pkg SHALL hold the state enumeration and the legal BLK values.
REQ-030 The row counter SHALL be a sub-module satd_row_counter with inputs clear, inc and limit, and outputs count and last.
REQ-031 The implementation SHALL NOT add any datapath arithmetic; this block is control only.

Verification
REQ-032 Reset, then start=1, half=0, in_valid=1, BLK=8 -> diff_en for 8 cycles, ver_en for 8, acc_en for 8 with acc_clr on the first, done high 25 cycles after start.
REQ-033 Same run with half=1 -> each phase lasts 4 cycles, row_idx stays within 0..3, done arrives 13 cycles after start.
REQ-034 in_valid=0 for 3 cycles while row_idx=2 in LOAD -> row_idx holds at 2, diff_en=0 during the gap, done arrives 3 cycles later (28).
REQ-035 start pulsed during VERT -> ignored, exactly one done; start held high in the DONE cycle -> LOAD on the next cycle, second done after 3*L+1 more cycles.
REQ-036 reset=0 asserted during ACC -> IDLE next cycle, all enables 0, no done pulse, ready=1 after release.
